mem2_load_unit: RTL

MEM2_LOAD_UNIT -- requirements
Module: mem2_load_unit

---
 rtl/mem2_load_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem2_load_unit.sv
// MEM2 load-return unit: tracks the single outstanding dcache load, aligns and
// extends the returned word, and buffers it while WB applies backpressure.

module mem2_load_align (
  input  logic [2:0]  load_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);
  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half = addr_lo[1] ? word[31:16] : word[15:0];
    case (addr_lo)
      2'b00:   byte_sel = word[7:0];
      2'b01:   byte_sel = word[15:8];
      2'b10:   byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    case (load_type)
      3'b001:  data = {{16{half[15]}}, half};
      3'b010:  data = {16'h0, half};
      3'b011:  data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  data = {24'h0, byte_sel};
      default: data = word;  // LW and the unused encodings
    endcase
  end
endmodule

module mem2_load_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem2_valid,
  input  logic        mem2_is_load,
  input  logic [2:0]  mem2_load_type,
  input  logic [1:0]  mem2_addr_lo,
  input  logic        mem2_flush,
  input  logic        wb_allow,
  input  logic        dcache_data_ok,
  input  logic [31:0] dcache_rdata,
  output logic [31:0] load_data,
  output logic        load_data_valid,
  output logic        mem2_stall_req
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [31:0] buffer;
  logic        capture;
  logic        load_present;
  logic        from_rdata;
  logic [31:0] word;
  logic [31:0] aligned;

  assign load_present = mem2_valid & mem2_is_load & ~mem2_flush;

  // A response in IDLE only belongs to us if a load is actually present.
  assign from_rdata = dcache_data_ok &
                      (((state == IDLE) & load_present) | (state == WAIT));

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: if (load_present) begin
        if (!dcache_data_ok)  state_nxt = WAIT;
        else if (!wb_allow) begin
          state_nxt = HOLD;
          capture   = 1'b1;
        end
      end
      WAIT: begin
        if (mem2_flush)          state_nxt = dcache_data_ok ? IDLE : DRAIN;
        else if (dcache_data_ok) begin
          if (wb_allow) state_nxt = IDLE;
          else begin
            state_nxt = HOLD;
            capture   = 1'b1;
          end
        end
      end
      HOLD:  if (mem2_flush || wb_allow) state_nxt = IDLE;
      default: if (dcache_data_ok)       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      buffer <= 32'h0;
    end else begin
      state <= state_nxt;
      if (capture) buffer <= dcache_rdata;
    end
  end

  always_comb begin
    word = 32'h0;
    if (from_rdata)          word = dcache_rdata;
    else if (state == HOLD)  word = buffer;
  end

  mem2_load_align u_align (
    .load_type (mem2_load_type),
    .addr_lo   (mem2_addr_lo),
    .word      (word),
    .data      (aligned)
  );

  assign load_data_valid = (from_rdata | (state == HOLD)) & ~mem2_flush;
  assign load_data       = load_data_valid ? aligned : 32'h0;

  // HOLD never stalls: the WB stall already freezes MEM2.
  assign mem2_stall_req = ((state == WAIT) & ~dcache_data_ok) |
                          ((state == IDLE) & load_present & ~dcache_data_ok) |
                          (state == DRAIN);
endmodule
